// File: rtl/degamma_lut_interp.sv
// Degamma curve engine: NK programmable knots, 3-stage linear interpolation pipeline.
// Optional knot readback port enabled by DEGAMMA_LUT_RDBACK_EN.
module degamma_lut_interp #(
  parameter int IN_BW  = 10,
  parameter int OUT_BW = 12,
  parameter int SEG_BW = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              lut_reinit,
  output logic              init_done,
  input  logic              cfg_we,
  input  logic [SEG_BW:0]   cfg_addr,
  input  logic [OUT_BW-1:0] cfg_wdata,
`ifdef DEGAMMA_LUT_RDBACK_EN
  input  logic              cfg_re,
  output logic [OUT_BW-1:0] cfg_rdata,
`endif
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [IN_BW-1:0]  pix_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_BW-1:0] pix_out
);

  localparam int NK      = (1 << SEG_BW) + 1;
  localparam int FRAC_BW = IN_BW - SEG_BW;
  localparam int AW      = SEG_BW + 1;
  localparam int PW      = OUT_BW + FRAC_BW + 1;
  localparam int YW      = PW + 1;
  localparam logic signed [YW-1:0] RND  = YW'(2 ** (FRAC_BW - 1));
  localparam logic signed [YW-1:0] MAXV = YW'(2 ** OUT_BW - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  function automatic logic [OUT_BW-1:0] ramp_knot(input logic [AW-1:0] k);
    logic [OUT_BW:0] s;
    s = (OUT_BW+1)'(k) << (OUT_BW - SEG_BW);
    if (s > (OUT_BW+1)'(2 ** OUT_BW - 1)) ramp_knot = '1;
    else                                 ramp_knot = s[OUT_BW-1:0];
  endfunction

  // Round half up via floor shift, then clamp to the output range.
  function automatic logic [OUT_BW-1:0] round_sat(input logic [OUT_BW-1:0] base,
                                                  input logic signed [PW-1:0] p);
    logic signed [YW-1:0] y;
    y = (YW'(p) + RND) >>> FRAC_BW;
    y = y + $signed(YW'({1'b0, base}));
    if (y < 0)         round_sat = '0;
    else if (y > MAXV) round_sat = '1;
    else               round_sat = y[OUT_BW-1:0];
  endfunction

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [OUT_BW-1:0] knot_q [NK];
  logic              knot_we;
  logic [AW-1:0]     knot_waddr;
  logic [OUT_BW-1:0] knot_wdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    knot_we    = 1'b0;
    knot_waddr = cnt_q;
    knot_wdata = ramp_knot(cnt_q);
    case (state_q)
      S_INIT: begin
        knot_we = 1'b1;
        if (lut_reinit) begin
          cnt_d = '0;
        end else if (cnt_q == AW'(NK - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (lut_reinit) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end else if (cfg_we && (cfg_addr < AW'(NK))) begin
          knot_we    = 1'b1;
          knot_waddr = cfg_addr;
          knot_wdata = cfg_wdata;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NK; i++) knot_q[i] <= '0;
    end else if (knot_we) begin
      knot_q[knot_waddr] <= knot_wdata;
    end
  end

  logic advance, accept;
  logic vld_p1_q, vld_p2_q, vld_p3_q;

  assign init_done = (state_q == S_RUN);
  assign advance   = ~vld_p3_q | out_ready;
  assign pix_ready = init_done & advance;
  assign accept    = pix_valid & pix_ready;
  assign out_valid = vld_p3_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else if (lut_reinit) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else if (advance) begin
      vld_p1_q <= accept;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
    end
  end

  // Stage 1: knot lookup
  logic [AW-1:0]        idx_lo, idx_hi;
  logic [OUT_BW-1:0]    lo_p1_q, hi_p1_q, lo_p2_q;
  logic [FRAC_BW-1:0]   frac_p1_q;
  logic signed [OUT_BW:0] diff_p1;
  logic signed [PW-1:0] prod_p1, prod_p2_q;

  assign idx_lo = AW'(pix_in[IN_BW-1:FRAC_BW]);
  assign idx_hi = idx_lo + 1'b1;

  // Stage 2: slope times fraction
  assign diff_p1 = $signed({1'b0, hi_p1_q}) - $signed({1'b0, lo_p1_q});
  assign prod_p1 = PW'(diff_p1) * PW'($signed({1'b0, frac_p1_q}));

  always_ff @(posedge clk) begin
    if (advance) begin
      lo_p1_q   <= knot_q[idx_lo];
      hi_p1_q   <= knot_q[idx_hi];
      frac_p1_q <= pix_in[FRAC_BW-1:0];
      lo_p2_q   <= lo_p1_q;
      prod_p2_q <= prod_p1;
    end
  end

  // Stage 3: round, add base, clamp
  logic [OUT_BW-1:0] pix_out_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_out_q <= '0;
    end else if (advance && vld_p2_q) begin
      pix_out_q <= round_sat(lo_p2_q, prod_p2_q);
    end
  end

  assign pix_out = pix_out_q;

`ifdef DEGAMMA_LUT_RDBACK_EN
  logic [OUT_BW-1:0] rdata_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= '0;
    end else if (cfg_re) begin
      rdata_q <= (cfg_addr < AW'(NK)) ? knot_q[cfg_addr] : '0;
    end
  end

  assign cfg_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_degamma_lut_interp.sv
// Directed + randomized bench for degamma_lut_interp against a knot-table model.
module tb_degamma_lut_interp;
  localparam int NK = 65;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        lut_reinit = 1'b0;
  logic        init_done;
  logic        cfg_we = 1'b0;
  logic [6:0]  cfg_addr = '0;
  logic [11:0] cfg_wdata = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [9:0]  pix_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] pix_out;
`ifdef DEGAMMA_LUT_RDBACK_EN
  logic        cfg_re = 1'b0;
  logic [11:0] cfg_rdata;
`endif

  int total = 0;
  int bad = 0;
  int mk[NK];

  degamma_lut_interp dut (
    .clk(clk), .rstn(rstn), .lut_reinit(lut_reinit), .init_done(init_done),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
`ifdef DEGAMMA_LUT_RDBACK_EN
    .cfg_re(cfg_re), .cfg_rdata(cfg_rdata),
`endif
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_in(pix_in),
    .out_valid(out_valid), .out_ready(out_ready), .pix_out(pix_out)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_ramp();
    for (int k = 0; k < NK; k++) mk[k] = (k * 64 > 4095) ? 4095 : k * 64;
  endfunction

  // Linear interpolation with round-half-up, floor semantics for negatives.
  function automatic int model_y(input int pix);
    int idx, f, lo, hi, t, q, y;
    idx = pix / 16;
    f   = pix % 16;
    lo  = mk[idx];
    hi  = mk[idx + 1];
    t   = (hi - lo) * f + 8;
    q   = (t >= 0) ? t / 16 : -((-t + 15) / 16);
    y   = lo + q;
    if (y < 0) y = 0;
    if (y > 4095) y = 4095;
    return y;
  endfunction

  task automatic cfg_write(input int addr, input int data, input bit honoured);
    cfg_we = 1'b1; cfg_addr = 7'(addr); cfg_wdata = 12'(data);
    tick();
    cfg_we = 1'b0;
    if (honoured && addr < NK) mk[addr] = data;
  endtask

  task automatic wait_out(input string tag, input int exp);
    int lat;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin tick(); lat++; end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_val"}, pix_out, exp);
    tick();
  endtask

  task automatic run_pix(input int pix, input int exp, input string tag);
    pix_in = 10'(pix); pix_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, pix_ready, 1);
    tick();
    pix_valid = 1'b0;
    wait_out(tag, exp);
  endtask

`ifdef DEGAMMA_LUT_RDBACK_EN
  task automatic rd_check(input int addr, input int exp, input string tag);
    cfg_re = 1'b1; cfg_addr = 7'(addr);
    tick();
    cfg_re = 1'b0;
    chk(tag, cfg_rdata, exp);
  endtask
`endif

  task automatic stream(input int n, input bit rnd, input string tag);
    int q[$];
    int sent, recv, cyc, cur;
    bit prev_stall;
    logic [11:0] prev_out;
    sent = 0; recv = 0; cyc = 0; prev_stall = 0; prev_out = '0;
    cur = rnd ? int'($urandom_range(0, 1023)) : 0;
    while (recv < n && cyc < 500) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : ((cyc % 4 == 0) || (cyc % 4 == 3));
      pix_valid = (sent < n);
      pix_in    = 10'(cur);
      #1;
      if (prev_stall) begin
        chk({tag, "_hold_vld"}, out_valid, 1);
        chk({tag, "_hold_val"}, pix_out, prev_out);
      end
      chk({tag, "_rdy"}, pix_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        chk({tag, "_pending"}, q.size() > 0, 1);
        if (q.size() > 0) chk({tag, "_val"}, pix_out, q.pop_front());
        recv++;
      end
      if (pix_valid && pix_ready) begin
        q.push_back(model_y(cur));
        sent++;
        cur = rnd ? int'($urandom_range(0, 1023)) : sent;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = pix_out;
      tick();
      cyc++;
    end
    pix_valid = 1'b0; out_ready = 1'b1;
    chk({tag, "_count"}, recv, n);
    chk({tag, "_leftover"}, q.size(), 0);
  endtask

  initial begin
    model_ramp();
    #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pix_out", pix_out, 0);
    tick(); tick();
    rstn = 1'b1;
    for (int i = 0; i <= 64; i++) begin
      chk("fill_init_done", init_done, 0);
`ifdef DEGAMMA_LUT_RDBACK_EN
      if (i == 30) begin cfg_re = 1'b1; cfg_addr = 7'd40; end
      if (i == 31) begin cfg_re = 1'b0; chk("rd_partial40", cfg_rdata, 0); end
`endif
      tick();
    end
    chk("fill_done", init_done, 1);

`ifdef DEGAMMA_LUT_RDBACK_EN
    rd_check(0, 0, "rd_k0");
    rd_check(21, 1344, "rd_k21");
    rd_check(63, 4032, "rd_k63");
    rd_check(64, 4095, "rd_k64");
    cfg_addr = 7'd0;
    tick();
    chk("rd_hold", cfg_rdata, 4095);
    rd_check(65, 0, "rd_oob");
`endif

    run_pix(10'h155, 1364, "pix155");
    run_pix(10'h3FF, 4091, "pix3ff");
    run_pix(10'h000, 0, "pix000");

    cfg_write(10, 1000, 1);
    cfg_write(11, 900, 1);
    run_pix(168, 950, "negslope");
    cfg_write(11, 4095, 1);
    cfg_write(10, 0, 1);
    run_pix(175, 3839, "steep");

    // Write to knot 21 in the same cycle the pixel samples it: old value wins.
    cfg_we = 1'b1; cfg_addr = 7'd21; cfg_wdata = 12'd0;
    pix_in = 10'h155; pix_valid = 1'b1; out_ready = 1'b1;
    tick();
    cfg_we = 1'b0; pix_valid = 1'b0;
    wait_out("wr_rd_same", 1364);
    mk[21] = 0;
    run_pix(10'h155, model_y(10'h155), "after_wr21");

`ifdef DEGAMMA_LUT_RDBACK_EN
    cfg_we = 1'b1; cfg_re = 1'b1; cfg_addr = 7'd22; cfg_wdata = 12'd7;
    tick();
    cfg_we = 1'b0; cfg_re = 1'b0; mk[22] = 7;
    chk("rd_wr_same", cfg_rdata, 1408);
    rd_check(22, 7, "rd_after_wr");
`endif

    stream(16, 0, "ramp");

    for (int k = 0; k < 6; k++) cfg_write(int'($urandom_range(0, 64)), int'($urandom_range(0, 4095)), 1);
    stream(40, 1, "rand");

    cfg_write(10, 1000, 1);
    out_ready = 1'b1; pix_valid = 1'b1;
    pix_in = 10'd5; tick();
    pix_in = 10'd6; tick();
    pix_in = 10'd7; lut_reinit = 1'b1;
    tick();
    lut_reinit = 1'b0; pix_valid = 1'b0;
    model_ramp();
    for (int i = 0; i <= 64; i++) begin
      chk("reinit_init_done", init_done, 0);
      chk("reinit_out_valid", out_valid, 0);
      if (i == 20) begin cfg_we = 1'b1; cfg_addr = 7'd5; cfg_wdata = 12'd0; end
      if (i == 21) cfg_we = 1'b0;
      tick();
    end
    chk("reinit_done", init_done, 1);
    run_pix(160, 640, "reinit_k10");
    run_pix(80, 320, "init_we_drop");
    cfg_write(65, 0, 0);
    cfg_write(127, 0, 0);
    run_pix(10'h3FF, 4091, "oob_we_drop");
`ifdef DEGAMMA_LUT_RDBACK_EN
    rd_check(10, 640, "rd_reinit_k10");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
